// File: rtl/frame_rx_arbiter.sv
// Round-robin arbiter giving two requesters shared use of one 3-byte frame receiver.
// Serialises the winner's frame MSB first, then collects the receiver's result or declares a timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs high, waiting for a request; picks winner and latches frame
// B0    | cs low, driving frame[23:16]
// B1    | cs low, driving frame[15:8]
// B2    | cs low, driving frame[7:0]
// WAIT  | cs high, waiting for rx_err / rx_ack or timeout
// DONE  | one-cycle done pulse to owner, round-robin pointer updated
// GAP   | cs held high before the next grant
module frame_rx_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] frame0,
  input  logic [23:0] frame1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [15:0] res,
  output logic [1:0]  status,
  output logic        cs,
  output logic [7:0]  rx_data,
  input  logic        rx_ack,
  input  logic        rx_err,
  input  logic [15:0] rx_res
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] B0   = 3'd1;
  localparam logic [2:0] B1   = 3'd2;
  localparam logic [2:0] B2   = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] GAPS = 3'd6;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic          owner;
  logic          rr_last;
  logic [23:0]   frame_q;
  logic [TW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;
  logic          win;
  logic [23:0]   frame_sel;
  logic [1:0]    owner_oh;

  // with both requests pending, the requester not served last wins
  assign win       = (req == 2'b11) ? ~rr_last : req[1];
  assign frame_sel = win ? frame1 : frame0;
  assign owner_oh  = owner ? 2'b10 : 2'b01;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nx = B0;
      B0:      state_nx = B1;
      B1:      state_nx = B2;
      B2:      state_nx = WAIT;
      WAIT:    if (rx_err || rx_ack || (wait_cnt == '0)) state_nx = DONE;
      DONE:    state_nx = GAPS;
      GAPS:    if (gap_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      frame_q  <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      grant    <= 2'b00;
      done     <= 2'b00;
      res      <= '0;
      status   <= ST_OK;
      cs       <= 1'b1;
      rx_data  <= 8'h00;
    end else begin
      state <= state_nx;
      done  <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner   <= win;
            frame_q <= frame_sel;
            grant   <= win ? 2'b10 : 2'b01;
            cs      <= 1'b0;
            rx_data <= frame_sel[23:16];
          end
        end
        B0: rx_data <= frame_q[15:8];
        B1: rx_data <= frame_q[7:0];
        B2: begin
          cs       <= 1'b1;
          rx_data  <= 8'h00;
          wait_cnt <= TW'(TIMEOUT - 1);
        end
        WAIT: begin
          // error outranks ack; a result in the last WAIT cycle beats the timeout
          if (rx_err) begin
            status <= ST_ERR;
            res    <= '0;
            done   <= owner_oh;
          end else if (rx_ack) begin
            status <= ST_OK;
            res    <= rx_res;
            done   <= owner_oh;
          end else if (wait_cnt == '0) begin
            status <= ST_TIMEOUT;
            res    <= '0;
            done   <= owner_oh;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        DONE: begin
          grant   <= 2'b00;
          rr_last <= owner;
          gap_cnt <= GW'(GAP - 1);
        end
        GAPS: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rx_arbiter.sv
// Directed and randomized checks of frame_rx_arbiter against a transaction-level model.
// The bench plays the receiver and both requesters; all checks happen on the falling edge.
module tb_frame_rx_arbiter;

  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  localparam int K_ACK    = 0;
  localparam int K_ERR    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [23:0] frame0;
  logic [23:0] frame1;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [15:0] res;
  logic [1:0]  status;
  logic        cs;
  logic [7:0]  rx_data;
  logic        rx_ack;
  logic        rx_err;
  logic [15:0] rx_res;

  int vectors     = 0;
  int miscompares = 0;
  int last_owner  = 1;

  always #5 clk = ~clk;

  frame_rx_arbiter #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .frame0(frame0), .frame1(frame1),
    .grant(grant), .done(done), .res(res), .status(status), .cs(cs),
    .rx_data(rx_data), .rx_ack(rx_ack), .rx_err(rx_err), .rx_res(rx_res)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - last_owner;
    return r[1] ? 1 : 0;
  endfunction

  task automatic wait_cs_low(input int exp_wait);
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (cs !== 1'b0 && waited < 8);
    chk("grant_latency", 32'(waited), 32'(exp_wait));
  endtask

  // One complete transaction: frame bytes, receiver response in WAIT cycle k, done, GAP.
  task automatic txn(input int kind, input int k, input logic [15:0] rv,
                     input logic [1:0] next_req, input int exp_wait);
    int          own;
    logic [1:0]  oh;
    logic [23:0] f;
    logic [15:0] exp_res;
    logic [1:0]  exp_status;
    own        = pick(req);
    oh         = (own == 1) ? 2'b10 : 2'b01;
    f          = (own == 1) ? frame1 : frame0;
    exp_res    = (kind == K_ACK) ? rv : 16'h0;
    exp_status = (kind == K_ACK) ? 2'b00 : (kind == K_SILENT) ? 2'b10 : 2'b01;
    wait_cs_low(exp_wait);
    chk("grant", 32'(grant), 32'(oh));
    chk("byte0", 32'(rx_data), 32'(f[23:16]));
    for (int b = 1; b < 3; b++) begin
      frame0 = 24'($urandom);
      frame1 = 24'($urandom);
      rx_ack = 1'($urandom);
      rx_err = 1'($urandom);
      @(negedge clk);
      chk("cs_low", 32'(cs), 32'd0);
      chk("byte", 32'(rx_data), (b == 1) ? 32'(f[15:8]) : 32'(f[7:0]));
    end
    rx_ack = 1'($urandom);
    rx_err = 1'($urandom);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      rx_ack = 1'b0;
      rx_err = 1'b0;
      rx_res = 16'($urandom);
      chk("wait_cs", 32'(cs), 32'd1);
      chk("wait_data", 32'(rx_data), 32'd0);
      chk("wait_done", 32'(done), 32'd0);
      if (j == k && kind != K_SILENT) begin
        rx_ack = (kind == K_ACK || kind == K_BOTH);
        rx_err = (kind == K_ERR || kind == K_BOTH);
        rx_res = rv;
      end
    end
    @(negedge clk);
    rx_ack = 1'b0;
    rx_err = 1'b0;
    rx_res = 16'($urandom);
    chk("done", 32'(done), 32'(oh));
    chk("res", 32'(res), 32'(exp_res));
    chk("status", 32'(status), 32'(exp_status));
    chk("grant_done", 32'(grant), 32'(oh));
    last_owner = own;
    req = next_req;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      rx_ack = 1'($urandom);
      chk("gap_cs", 32'(cs), 32'd1);
      chk("gap_grant", 32'(grant), 32'd0);
      chk("gap_done", 32'(done), 32'd0);
      chk("res_held", 32'(res), 32'(exp_res));
    end
    rx_ack = 1'b0;
  endtask

  initial begin
    int         kind;
    int         k;
    logic [1:0] nr;

    // reset held with both requests pending
    rst    = 1'b0;
    req    = 2'b11;
    frame0 = 24'h123456;
    frame1 = 24'h654321;
    rx_ack = 1'b0;
    rx_err = 1'b0;
    rx_res = 16'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_cs", 32'(cs), 32'd1);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
    end
    rst = 1'b1;
    txn(K_ACK, 3, 16'hBEEF, 2'b01, 1);

    // single requester 0, ack two cycles after cs rises
    frame0 = 24'hCAFF01;
    txn(K_ACK, 2, 16'hCAFF, 2'b11, 2);

    // both requesting continuously: grants alternate
    for (int i = 0; i < 3; i++) begin
      frame0 = 24'($urandom);
      frame1 = 24'($urandom);
      txn(K_ACK, int'($urandom_range(1, 4)), 16'($urandom), (i == 2) ? 2'b10 : 2'b11, 2);
    end

    // err and ack together: err wins
    frame1 = 24'hCC0000;
    txn(K_BOTH, 1, 16'h5A5A, 2'b01, 2);

    // silent receiver: timeout after exactly TIMEOUT WAIT cycles
    frame0 = 24'($urandom);
    txn(K_SILENT, TIMEOUT, 16'h0, 2'b01, 2);

    // ack in the final WAIT cycle beats the timeout
    frame0 = 24'($urandom);
    txn(K_ACK, TIMEOUT, 16'h7E81, 2'b11, 2);

    // randomized mix of requests and receiver behaviour
    for (int i = 0; i < 14; i++) begin
      frame0 = 24'($urandom);
      frame1 = 24'($urandom);
      kind   = int'($urandom_range(0, 3));
      k      = (kind == K_SILENT) ? TIMEOUT : int'($urandom_range(1, TIMEOUT));
      nr     = (i == 13) ? 2'b01 : 2'($urandom_range(1, 3));
      txn(kind, k, 16'($urandom), nr, 2);
    end

    // reset during B1 aborts the frame; it is resent from the start afterwards
    frame0 = 24'hA1B2C3;
    wait_cs_low(2);
    chk("abort_byte0", 32'(rx_data), 32'hA1);
    @(negedge clk);
    chk("abort_byte1", 32'(rx_data), 32'hB2);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_data", 32'(rx_data), 32'd0);
    rst = 1'b1;
    last_owner = 1;
    txn(K_ACK, 2, 16'h1357, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_rx_arbiter.md
Name: frame_rx_arbiter

Overview:
Shares one 3-byte frame receiver (cs-framed byte input, 16-bit result with ack/err) between two requesters. Grants by round-robin, serialises the winner's 24-bit frame onto the receiver bus MSB first under active-low cs, then waits for ack/err with a timeout. Returns the 16-bit result and a status code to the winner. Sits between the requester logic and the receiver; it is the receiver's only bus master.

Parameters:
TIMEOUT, 16, max cycles in WAIT before the frame is declared lost (≥1, counter width $clog2(TIMEOUT+1))
GAP, 2, cycles cs held high after DONE before the next grant (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets)
req  in  2  request per requester; held high until its done pulse
frame0  in  24  requester 0 frame, sampled at grant
frame1  in  24  requester 1 frame, sampled at grant
grant  out  2  one-hot owner, high from B0 through DONE
done  out  2  one-cycle pulse to owner in DONE
res  out  16  result, valid while done is high, held until next DONE
status  out  2  00 ok, 01 receiver err, 10 timeout; valid with done
cs  out  1  receiver chip select, active-low
rx_data  out  8  byte to receiver
rx_ack  in  1  receiver result valid
rx_err  in  1  receiver frame error
rx_res  in  16  receiver result

Behaviour:
- All outputs registered (Moore). Reset values: state IDLE, cs=1, rx_data=8'h00, grant=0, done=0, res=0, status=0, rr pointer favours req[0], counters 0.
- States: IDLE, B0, B1, B2, WAIT, DONE, GAP.
- IDLE: if req nonzero, pick winner. If only one request is high, that requester wins. If both are high, the one not granted last wins (rr pointer). Latch the frame, set grant, go to B0. Otherwise stay.
- B0/B1/B2: cs=0; rx_data = frame[23:16], [15:8], [7:0] respectively. This gives exactly 3 consecutive cs-low cycles, with the first byte driven one cycle after the IDLE sampling edge.
- WAIT: cs=1, rx_data=0, wait counter increments each cycle.
  - rx_err=1: capture status=01, res=0.
  - else rx_ack=1: capture res=rx_res, status=00.
  - rx_err has priority if both arrive in the same cycle.
  - Counter reaches TIMEOUT with neither: status=10, res=0.
  - Any of these goes to DONE.
- rx_ack/rx_err during IDLE, B0–B2, DONE or GAP are ignored.
- DONE: done[owner]=1 for exactly one cycle; rr pointer updated to owner. Go to GAP, clear grant.
- GAP: cs=1 for GAP cycles, then IDLE.
- A req still high at IDLE after its done counts as a new request; the rr pointer lets the other requester win if both are high.
- A req dropped mid-transaction does not abort it; done is still pulsed.
- Frame latched at grant, so frame changes after grant have no effect.
- Latency: IDLE sample edge → DONE is 3 + k + 1 cycles, where k (1..TIMEOUT) is the WAIT cycle in which status resolves. Minimum 5 cycles.
- Reset mid-operation: next edge returns to reset values, cs high, no done pulse, frame discarded.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with req=2'b11 → cs=1, grant=0, done=0. Release → grant=01 on next cycle (pointer favours 0).
2. req=01, frame0=24'hCAFF01; receiver acks with rx_res=16'hCAFF 2 cycles after cs rises → cs low for exactly 3 cycles carrying CA, FF, 01. Then done=01 with res=16'hCAFF, status=00, followed by GAP=2 cycles of cs high.
3. req=11 held continuously, receiver always acks → grants alternate 01, 10, 01; each done goes to the matching requester.
4. req=10, frame1=24'hCC0000; receiver asserts rx_err and rx_ack in the same WAIT cycle → done=10, status=01, res=0.
5. req=01, receiver silent → done=01 exactly TIMEOUT=16 cycles after entering WAIT, status=10, res=0.
6. Assert rst=0 during B1 → cs=1 at next edge, no done pulse. After release with req still high, the full frame is resent from B0.
